// File: rtl/status_irq_ctrl_if.sv
// Host register-bus bundle for status_irq_ctrl.
// master = host side, slave = controller side.
interface status_irq_ctrl_if #(
    parameter int unsigned Channels = 4
);
    logic                  we_i;
    logic [Channels-1:0]   enable_i;
    logic                  clr_i;
    logic [Channels-1:0]   clr_mask_i;
    logic                  read_i;
    logic [Channels-1:0]   enable_o;
    logic [Channels-1:0]   pending_o;
    logic [Channels-1:0]   overflow_o;
    logic [3*Channels-1:0] status_o;
    logic                  irq_o;
    logic                  holdoff_active_o;

    modport master (
        output we_i, enable_i, clr_i, clr_mask_i, read_i,
        input  enable_o, pending_o, overflow_o, status_o,
        input  irq_o, holdoff_active_o
    );

    modport slave (
        input  we_i, enable_i, clr_i, clr_mask_i, read_i,
        output enable_o, pending_o, overflow_o, status_o,
        output irq_o, holdoff_active_o
    );
endinterface

// File: rtl/status_irq_ctrl.sv
// Status/interrupt controller: per-channel edge/level triggers,
// sticky pending + overflow, W1C / clear-on-read, irq holdoff.
module status_irq_ctrl #(
    parameter int unsigned       Channels      = 4,
    parameter logic [Channels-1:0] EdgeMask    = '0,
    parameter logic [Channels-1:0] ResetEnable = '0,
    parameter bit                ClearOnRead   = 1'b1,
    parameter int unsigned       HoldoffCycles = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [Channels-1:0] event_i,
    status_irq_ctrl_if.slave    bus
);

    localparam int unsigned CntW =
        (HoldoffCycles > 0) ? $clog2(HoldoffCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(HoldoffCycles);
    localparam bit HoldoffOn = (HoldoffCycles > 0);

    logic [Channels-1:0] prev_q;
    logic [Channels-1:0] en_q;
    logic [Channels-1:0] pend_q;
    logic [Channels-1:0] ovf_q;
    logic [CntW-1:0]     cnt_q;
    logic                act_q;

    logic [Channels-1:0] trig;
    logic [Channels-1:0] clr_pend;
    logic [Channels-1:0] clr_ovf;
    logic [Channels-1:0] pend_d;
    logic [Channels-1:0] ovf_d;
    logic [Channels-1:0] en_d;
    logic [CntW-1:0]     cnt_d;
    logic                active;
    logic                fall;
    logic                rd_clr;

    // Edge channels fire once per rising edge; level channels follow input.
    always_comb begin
        trig = (event_i & ~prev_q & EdgeMask)
             | (event_i & ~EdgeMask);
    end

    // Read-clear only touches bits visible as 1 in status_o.
    always_comb begin
        rd_clr   = ClearOnRead && bus.read_i;
        clr_pend = '0;
        clr_ovf  = '0;
        if (bus.clr_i) begin
            clr_pend = clr_pend | bus.clr_mask_i;
            clr_ovf  = clr_ovf | bus.clr_mask_i;
        end
        if (rd_clr) begin
            clr_pend = clr_pend | pend_q;
            clr_ovf  = clr_ovf | ovf_q;
        end
    end

    // Enabled: sticky with set-wins. Disabled: transparent.
    always_comb begin
        pend_d = '0;
        ovf_d  = '0;
        for (int c = 0; c < Channels; c++) begin
            if (en_q[c]) begin
                pend_d[c] = trig[c] | (pend_q[c] & ~clr_pend[c]);
                ovf_d[c]  = (trig[c] & pend_q[c])
                          | (ovf_q[c] & ~clr_ovf[c]);
            end else begin
                pend_d[c] = trig[c];
                ovf_d[c]  = 1'b0;
            end
        end
    end

    always_comb begin
        en_d = en_q;
        if (bus.we_i) begin
            en_d = bus.enable_i;
        end
    end

    always_comb begin
        active = |(pend_q & en_q);
        fall   = act_q & ~active;
    end

    // Load on a registered fall so irq stays low for HoldoffCycles
    // full cycles after the one in which it dropped.
    always_comb begin
        cnt_d = cnt_q;
        if (HoldoffOn && fall) begin
            cnt_d = CntLoad;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= '0;
            en_q   <= ResetEnable;
            pend_q <= '0;
            ovf_q  <= '0;
            cnt_q  <= '0;
            act_q  <= 1'b0;
        end else begin
            prev_q <= event_i;
            en_q   <= en_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
            act_q  <= active;
        end
    end

    always_comb begin
        bus.enable_o         = en_q;
        bus.pending_o        = pend_q;
        bus.overflow_o       = ovf_q;
        bus.status_o         = {ovf_q, en_q, pend_q};
        bus.irq_o            = active & (cnt_q == '0);
        bus.holdoff_active_o = (cnt_q != '0);
    end

endmodule
